// File: rtl/pipe_hazard_ctrl.sv
// OTTER pipeline hazard unit: RAW detection, operand forwarding,
// load-use stalls, taken-branch flushes and stall/flush counters.
module pipe_hazard_ctrl #(
    parameter int DEPTH      = 3,
    parameter int LOAD_READY = 2,
    parameter int REG_AW     = 5,
    parameter int CNT_W      = 32,
    parameter int SEL_W      = $clog2(DEPTH + 1)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              de_valid,
    input  logic [REG_AW-1:0] de_rs1_addr,
    input  logic [REG_AW-1:0] de_rs2_addr,
    input  logic [REG_AW-1:0] de_rd_addr,
    input  logic              de_rs1_used,
    input  logic              de_rs2_used,
    input  logic              de_rd_used,
    input  logic              de_is_load,
    input  logic              ex_br_taken,
    output logic              pc_write,
    output logic              if_de_en,
    output logic              if_flush,
    output logic              de_flush,
    output logic [SEL_W-1:0]  fwd_a_sel,
    output logic [SEL_W-1:0]  fwd_b_sel,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic              sb_v  [DEPTH];
    logic [REG_AW-1:0] sb_rd [DEPTH];
    logic              sb_ld [DEPTH];

    logic             chk_a, chk_b;
    logic             lu_a, lu_b;
    logic [SEL_W-1:0] sel_a, sel_b;
    logic             stall, flush;

    assign chk_a = de_valid && de_rs1_used && (de_rs1_addr != '0);
    assign chk_b = de_valid && de_rs2_used && (de_rs2_addr != '0);

    // Scan oldest to youngest so the youngest matching entry wins.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        lu_a  = 1'b0;
        lu_b  = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (chk_a && sb_v[i] && (sb_rd[i] == de_rs1_addr)) begin
                sel_a = SEL_W'(i + 1);
                lu_a  = sb_ld[i] && (i < LOAD_READY);
            end
            if (chk_b && sb_v[i] && (sb_rd[i] == de_rs2_addr)) begin
                sel_b = SEL_W'(i + 1);
                lu_b  = sb_ld[i] && (i < LOAD_READY);
            end
        end
    end

    assign flush     = !RST && ex_br_taken;
    assign stall     = !RST && !ex_br_taken && (lu_a || lu_b);
    assign pc_write  = !stall;
    assign if_de_en  = !stall;
    assign if_flush  = flush;
    assign de_flush  = flush || stall;
    assign fwd_a_sel = RST ? '0 : sel_a;
    assign fwd_b_sel = RST ? '0 : sel_b;

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                sb_v[i]  <= 1'b0;
                sb_rd[i] <= '0;
                sb_ld[i] <= 1'b0;
            end
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                sb_v[i]  <= sb_v[i-1];
                sb_rd[i] <= sb_rd[i-1];
                sb_ld[i] <= sb_ld[i-1];
            end
            if (de_flush) begin
                sb_v[0]  <= 1'b0;
                sb_rd[0] <= '0;
                sb_ld[0] <= 1'b0;
            end else begin
                sb_v[0]  <= de_valid && de_rd_used && (de_rd_addr != '0);
                sb_rd[0] <= de_rd_addr;
                sb_ld[0] <= de_is_load;
            end
            if (stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            if (flush && (flush_cnt != '1))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; a CNT_W=4 twin shares
// the stimulus to exercise counter saturation.
module tb_pipe_hazard_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic       de_valid;
    logic [4:0] de_rs1_addr, de_rs2_addr, de_rd_addr;
    logic       de_rs1_used, de_rs2_used, de_rd_used, de_is_load;
    logic       ex_br_taken;

    logic        pc_write, if_de_en, if_flush, de_flush;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic [31:0] stall_cnt, flush_cnt;

    logic        pc_write4, if_de_en4, if_flush4, de_flush4;
    logic [1:0]  fwd_a_sel4, fwd_b_sel4;
    logic [3:0]  stall_cnt4, flush_cnt4;

    int nchk = 0;
    int nerr = 0;

    always #5 CLK = ~CLK;

    pipe_hazard_ctrl dut (
        .CLK(CLK), .RST(RST), .de_valid(de_valid),
        .de_rs1_addr(de_rs1_addr), .de_rs2_addr(de_rs2_addr),
        .de_rd_addr(de_rd_addr), .de_rs1_used(de_rs1_used),
        .de_rs2_used(de_rs2_used), .de_rd_used(de_rd_used),
        .de_is_load(de_is_load), .ex_br_taken(ex_br_taken),
        .pc_write(pc_write), .if_de_en(if_de_en),
        .if_flush(if_flush), .de_flush(de_flush),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_hazard_ctrl #(.CNT_W(4)) dut4 (
        .CLK(CLK), .RST(RST), .de_valid(de_valid),
        .de_rs1_addr(de_rs1_addr), .de_rs2_addr(de_rs2_addr),
        .de_rd_addr(de_rd_addr), .de_rs1_used(de_rs1_used),
        .de_rs2_used(de_rs2_used), .de_rd_used(de_rd_used),
        .de_is_load(de_is_load), .ex_br_taken(ex_br_taken),
        .pc_write(pc_write4), .if_de_en(if_de_en4),
        .if_flush(if_flush4), .de_flush(de_flush4),
        .fwd_a_sel(fwd_a_sel4), .fwd_b_sel(fwd_b_sel4),
        .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        nchk++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic sample;
        @(negedge CLK);
    endtask

    task automatic instr(input logic v, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd,
                         input logic u1, input logic u2,
                         input logic ud, input logic ld);
        de_valid    = v;
        de_rs1_addr = rs1;
        de_rs2_addr = rs2;
        de_rd_addr  = rd;
        de_rs1_used = u1;
        de_rs2_used = u2;
        de_rd_used  = ud;
        de_is_load  = ld;
    endtask

    task automatic idle(input int n);
        instr(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic expect_ctl(input string tag, input logic pw,
                              input logic fl_if, input logic fl_de);
        check({tag, ".pc_write"}, 32'(pc_write), 32'(pw));
        check({tag, ".if_de_en"}, 32'(if_de_en), 32'(pw));
        check({tag, ".if_flush"}, 32'(if_flush), 32'(fl_if));
        check({tag, ".de_flush"}, 32'(de_flush), 32'(fl_de));
    endtask

    initial begin
        RST = 1'b1;
        ex_br_taken = 1'b0;
        instr(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        sample();
        expect_ctl("rst_hold", 1, 0, 0);
        check("rst_stall_cnt", stall_cnt, 0);
        check("rst_flush_cnt", flush_cnt, 0);
        #1;
        RST = 1'b0;

        for (int c = 0; c < 5; c++) begin
            sample();
            expect_ctl("idle", 1, 0, 0);
            check("idle_sel_a", 32'(fwd_a_sel), 0);
            check("idle_sel_b", 32'(fwd_b_sel), 0);
            tick();
        end
        check("idle_stall_cnt", stall_cnt, 0);
        check("idle_flush_cnt", flush_cnt, 0);

        // addi x5 ; add x6,x5,x1
        instr(1, 0, 0, 5, 1, 0, 1, 0);
        tick();
        instr(1, 5, 1, 6, 1, 1, 1, 0);
        sample();
        expect_ctl("alu_fwd", 1, 0, 0);
        check("alu_fwd_a", 32'(fwd_a_sel), 1);
        check("alu_fwd_b", 32'(fwd_b_sel), 0);
        tick();
        idle(3);

        // lw x7 ; sub x8,x1,x7
        instr(1, 2, 0, 7, 1, 0, 1, 1);
        tick();
        instr(1, 1, 7, 8, 1, 1, 1, 0);
        sample();
        expect_ctl("lu_stall1", 0, 0, 1);
        check("lu_stall1_cnt", stall_cnt, 0);
        tick();
        sample();
        expect_ctl("lu_stall2", 0, 0, 1);
        check("lu_stall2_cnt", stall_cnt, 1);
        tick();
        sample();
        expect_ctl("lu_release", 1, 0, 0);
        check("lu_fwd_a", 32'(fwd_a_sel), 0);
        check("lu_fwd_b", 32'(fwd_b_sel), 3);
        check("lu_stall_cnt", stall_cnt, 2);
        tick();
        idle(3);

        // addi x0,x0,1 ; reader of x0
        instr(1, 0, 0, 0, 1, 0, 1, 0);
        tick();
        instr(1, 0, 0, 9, 1, 1, 1, 0);
        sample();
        expect_ctl("x0_read", 1, 0, 0);
        check("x0_sel_a", 32'(fwd_a_sel), 0);
        check("x0_sel_b", 32'(fwd_b_sel), 0);
        tick();
        idle(3);
        // lw x0 ; reader of x0 must not stall
        instr(1, 3, 0, 0, 1, 0, 1, 1);
        tick();
        instr(1, 0, 0, 10, 1, 1, 1, 0);
        sample();
        expect_ctl("x0_load", 1, 0, 0);
        check("x0_load_sel", 32'(fwd_a_sel), 0);
        tick();
        idle(3);

        // addi x5 ; addi x11 ; addi x5 ; add x12,x5,x11
        instr(1, 0, 0, 5, 1, 0, 1, 0);
        tick();
        instr(1, 0, 0, 11, 1, 0, 1, 0);
        tick();
        instr(1, 0, 0, 5, 1, 0, 1, 0);
        tick();
        instr(1, 5, 11, 12, 1, 1, 1, 0);
        sample();
        expect_ctl("young_win", 1, 0, 0);
        check("young_sel_a", 32'(fwd_a_sel), 1);
        check("young_sel_b", 32'(fwd_b_sel), 2);
        tick();
        idle(3);

        // lw x9 ; consumer with taken branch in EX
        instr(1, 2, 0, 9, 1, 0, 1, 1);
        tick();
        instr(1, 9, 0, 13, 1, 0, 1, 0);
        ex_br_taken = 1'b1;
        sample();
        expect_ctl("br_pri", 1, 1, 1);
        tick();
        ex_br_taken = 1'b0;
        instr(0, 0, 0, 0, 0, 0, 0, 0);
        sample();
        check("br_flush_cnt", flush_cnt, 1);
        check("br_stall_cnt", stall_cnt, 2);
        idle(3);

        // 20 consecutive flush cycles
        ex_br_taken = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        ex_br_taken = 1'b0;
        sample();
        check("sat_flush_cnt4", 32'(flush_cnt4), 15);
        check("sat_flush_cnt32", flush_cnt, 21);
        check("sat_stall_cnt4", 32'(stall_cnt4), 2);
        idle(3);

        // reset asserted while a load-use stall is active
        instr(1, 2, 0, 12, 1, 0, 1, 1);
        tick();
        instr(1, 1, 12, 14, 1, 1, 1, 0);
        sample();
        expect_ctl("mid_stall", 0, 0, 1);
        #1;
        RST = 1'b1;
        #1;
        expect_ctl("mid_rst", 1, 0, 0);
        tick();
        RST = 1'b0;
        sample();
        expect_ctl("post_rst", 1, 0, 0);
        check("post_rst_sel_b", 32'(fwd_b_sel), 0);
        check("post_rst_stall", stall_cnt, 0);
        check("post_rst_flush", flush_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised hazard and forwarding controller for the 5-stage OTTER pipeline.
- Removes the "no hazards" limitation: detects RAW hazards at decode, selects operand forwarding sources, stalls on load-use, and flushes younger instructions on a taken branch or jump resolved in execute.
- Keeps a scoreboard shift register of in-flight destination registers and saturating stall/flush performance counters.
- Sits beside the decode/execute stages; drives PC_WRITE, the pipeline-register enables/bubbles and the ALU-operand forwarding muxes.

Parameters:
- DEPTH, 3, in-flight stages tracked after decode (index 0 = EX, 1 = MEM, 2 = WB); legal range 2..6.
- LOAD_READY, 2, scoreboard index at which load data becomes forwardable; must be < DEPTH.
- REG_AW, 5, register address width.
- CNT_W, 32, width of the performance counters.
- SEL_W, $clog2(DEPTH+1), width of the forwarding selects.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset.
- de_valid  in  1  decode stage holds a real instruction.
- de_rs1_addr  in  REG_AW  rs1 address.
- de_rs2_addr  in  REG_AW  rs2 address.
- de_rd_addr  in  REG_AW  rd address.
- de_rs1_used  in  1  instruction reads rs1.
- de_rs2_used  in  1  instruction reads rs2.
- de_rd_used  in  1  instruction writes rd.
- de_is_load  in  1  instruction is a LOAD.
- ex_br_taken  in  1  EX resolved a taken branch, JAL or JALR.
- pc_write  out  1  PC enable (0 = hold).
- if_de_en  out  1  IF/DE register enable.
- if_flush  out  1  replace the IF/DE contents with a bubble.
- de_flush  out  1  insert a bubble into DE/EX.
- fwd_a_sel  out  SEL_W  0 = register file; k = result of scoreboard entry k-1.
- fwd_b_sel  out  SEL_W  same, for rs2.
- stall_cnt  out  CNT_W  count of load-use stall cycles.
- flush_cnt  out  CNT_W  count of taken-branch flush cycles.

Behaviour:
- Clock and reset: single clock CLK; RST is synchronous and active-high.
- Reset state: all scoreboard entries invalid; counters 0.
- Outputs while RST is high: pc_write=1, if_de_en=1, if_flush=0, de_flush=0, fwd selects 0, counters read 0 on the cycle after the reset edge.
- Scoreboard entry fields: {valid, rd, is_load}. Valid is set only if de_valid, de_rd_used and de_rd_addr != 0.
- Scoreboard shift, every cycle: entry[i] <= entry[i-1] for i >= 1; entry[DEPTH-1] is discarded.
- Scoreboard entry[0] load: gets the decode instruction, or a bubble (valid=0) when de_flush=1.
- Hazard match, per source operand: the source is checked if de_valid, its used flag is 1 and its address != 0. The match is the lowest-index (youngest) valid entry i with rd == addr.
- Forwarding select: sel = i+1 if the match exists, else 0. x0 never forwards.
- Load-use detection: hazard when the matched entry has is_load=1 and i < LOAD_READY.
- Stall (load-use on either operand and ex_br_taken=0): pc_write=0, if_de_en=0, de_flush=1, stall_cnt +1.
- Flush (ex_br_taken=1): if_flush=1, de_flush=1, pc_write=1, if_de_en=1, flush_cnt +1.
- Flush has priority over stall in the same cycle; the stall is dropped and stall_cnt does not increment.
- Forward selects are don't-care whenever de_flush=1, but must remain deterministic, computed by the same rule.
- Stall repeats each cycle until the load reaches LOAD_READY. With defaults, a load immediately followed by its consumer stalls exactly 2 cycles, then forwards with sel=3.
- Back-to-back matches: the youngest entry wins. Example: entries 0 and 2 both write x5 -> sel=1.
- Counters saturate at 2^CNT_W-1; no wrap.
- Latency: stall, flush and forward outputs are combinational from the current inputs and scoreboard state. Scoreboard state updates on the next edge.
- Reset mid-stall: next cycle the scoreboard is empty, so the stall releases.

Test Plan:
- Reset, then de_valid=0 for 5 cycles -> pc_write=1, if_de_en=1, if_flush=0, de_flush=0, sel=0, counters 0.
- `addi x5` then `add x6,x5,x1` in consecutive cycles -> on the second cycle fwd_a_sel=1, fwd_b_sel=0, no stall.
- `lw x7` then `sub x8,x1,x7` -> pc_write=0, de_flush=1 for 2 cycles, then fwd_b_sel=3, stall_cnt=2.
- `addi x0,x0,1` followed by a reader of x0 -> sel=0, no stall; an instruction writing x0 never enters the scoreboard as valid.
- ex_br_taken=1 in the same cycle as a load-use hazard -> if_flush=1, de_flush=1, pc_write=1, flush_cnt=1, stall_cnt unchanged.
- CNT_W=4: 20 consecutive flush cycles -> flush_cnt holds at 15. Assert RST mid-stall -> all entries invalid and stall released on the next cycle.
